// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared constants and types for the tile-map renderer (scanner + drawer).
//   - map geometry (columns, rows, tile edge) and derived screen size
//   - address / index widths for map RAM and tile ROM
//   - scanner FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package tile_pkg;

   localparam int TILE_PX    = 8;    // tile edge in pixels (power of two)
   localparam int TILE_BYTES = 192;  // 8x8 pixels x 3 bytes RGB
   localparam int MAP_COLS   = 20;
   localparam int MAP_ROWS   = 15;
   localparam int IDX_W      = 4;
   localparam int MAP_AW     = 9;
   localparam int ROM_AW     = 12;

   localparam int SCREEN_W   = MAP_COLS * TILE_PX;  // 160
   localparam int SCREEN_H   = MAP_ROWS * TILE_PX;  // 120

   localparam int POS_W      = 8;                   // screen coordinate width
   localparam int PX_SHIFT   = $clog2(TILE_PX);     // cell -> pixel shift
   localparam int COL_W      = $clog2(MAP_COLS);
   localparam int ROW_W      = $clog2(MAP_ROWS);

   // TILE_BYTES = 128 + 64, so idx*TILE_BYTES is a two-term shift-add.
   localparam int BASE_SH_HI = 7;
   localparam int BASE_SH_LO = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAP_READ,
      S_MAP_WAIT,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_DONE,
      S_ADVANCE,
      S_DONE
   } scan_state_t;

endpackage

// File: rtl/tilemap_scanner_if.sv
// ---------------------------------------------------------------------------
// tilemap_scanner_if
// Bundles the scanner's frame control, map RAM read port and tile drawer
// request port.
//   frame control : start, busy, frame_done
//   map RAM       : map_rd_en, map_addr, map_data (one-cycle read latency)
//   tile drawer   : draw, tile_base, x_pos, y_pos, drawer_active
//   status        : tiles_drawn
// Modports: master = scanner side, slave = environment (sequencer/RAM/drawer).
// ---------------------------------------------------------------------------
interface tilemap_scanner_if;
   import tile_pkg::*;

   logic                start;
   logic                busy;
   logic                frame_done;
   logic                map_rd_en;
   logic [MAP_AW-1:0]   map_addr;
   logic [IDX_W-1:0]    map_data;
   logic                draw;
   logic [ROM_AW-1:0]   tile_base;
   logic [POS_W-1:0]    x_pos;
   logic [POS_W-1:0]    y_pos;
   logic                drawer_active;
   logic [MAP_AW-1:0]   tiles_drawn;

   modport master (
      input  start, map_data, drawer_active,
      output busy, frame_done, map_rd_en, map_addr, draw,
             tile_base, x_pos, y_pos, tiles_drawn
   );

   modport slave (
      output start, map_data, drawer_active,
      input  busy, frame_done, map_rd_en, map_addr, draw,
             tile_base, x_pos, y_pos, tiles_drawn
   );

endinterface

// File: rtl/tilemap_scanner.sv
// ---------------------------------------------------------------------------
// tilemap_scanner
// Walks the MAP_COLS x MAP_ROWS tile map in row-major order on each frame
// start, reads one tile index per cell, and issues one draw request per
// non-empty cell to the tile drawer, waiting for each tile to complete.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : tilemap_scanner_if.master (frame control, map RAM, drawer)
// Parameter:
//   SKIP_ZERO : when 1, tile index 0 is an empty cell and is not drawn
// ---------------------------------------------------------------------------
module tilemap_scanner
   import tile_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   tilemap_scanner_if.master  bus
);

   scan_state_t          state;
   scan_state_t          state_nxt;

   logic [COL_W-1:0]     col;
   logic [ROW_W-1:0]     row;
   logic [MAP_AW-1:0]    map_addr_r;
   logic [MAP_AW-1:0]    tiles_drawn_r;
   logic [IDX_W-1:0]     idx;
   logic                 idx_held;
   logic [ROM_AW-1:0]    tile_base_r;
   logic [POS_W-1:0]     x_pos_r;
   logic [POS_W-1:0]     y_pos_r;

   logic [IDX_W-1:0]     cur_idx;
   logic                 skip_cell;
   logic                 last_col;
   logic                 last_row;
   logic                 load_issue;

   // RAM data is only guaranteed the cycle after the read; while stalled in
   // MAP_WAIT we use the copy captured on the first wait cycle.
   assign cur_idx   = idx_held ? idx : bus.map_data;
   assign skip_cell = SKIP_ZERO && (cur_idx == '0);
   assign last_col  = (col == COL_W'(MAP_COLS - 1));
   assign last_row  = (row == ROW_W'(MAP_ROWS - 1));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      load_issue = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_MAP_READ;
         end
         S_MAP_READ: begin
            state_nxt = S_MAP_WAIT;
         end
         S_MAP_WAIT: begin
            if (skip_cell) begin
               state_nxt = S_ADVANCE;
            end else if (!bus.drawer_active) begin
               state_nxt  = S_ISSUE;
               load_issue = 1'b1;
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (bus.drawer_active) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!bus.drawer_active) state_nxt = S_ADVANCE;
         end
         S_ADVANCE: begin
            if (last_col && last_row) state_nxt = S_DONE;
            else                      state_nxt = S_MAP_READ;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Walk position, tile index and draw parameters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col           <= '0;
         row           <= '0;
         map_addr_r    <= '0;
         tiles_drawn_r <= '0;
         idx           <= '0;
         idx_held      <= 1'b0;
         tile_base_r   <= '0;
         x_pos_r       <= '0;
         y_pos_r       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  col           <= '0;
                  row           <= '0;
                  map_addr_r    <= '0;
                  tiles_drawn_r <= '0;
               end
            end
            S_MAP_READ: begin
               idx_held <= 1'b0;
            end
            S_MAP_WAIT: begin
               if (!idx_held) begin
                  idx      <= bus.map_data;
                  idx_held <= 1'b1;
               end
               // Draw parameters are loaded on the way into ISSUE so they
               // are already valid alongside the draw pulse.
               if (load_issue) begin
                  tile_base_r <= (ROM_AW'(cur_idx) << BASE_SH_HI)
                               + (ROM_AW'(cur_idx) << BASE_SH_LO);
                  x_pos_r     <= POS_W'(col) << PX_SHIFT;
                  y_pos_r     <= POS_W'(row) << PX_SHIFT;
               end
            end
            S_ISSUE: begin
               tiles_drawn_r <= tiles_drawn_r + MAP_AW'(1);
            end
            S_ADVANCE: begin
               // Row-major walk: the linear address simply counts up.
               map_addr_r <= map_addr_r + MAP_AW'(1);
               if (last_col) begin
                  col <= '0;
                  if (!last_row) row <= row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
   assign bus.frame_done  = (state == S_DONE);
   assign bus.map_rd_en   = (state == S_MAP_READ);
   assign bus.draw        = (state == S_ISSUE);
   assign bus.map_addr    = map_addr_r;
   assign bus.tile_base   = tile_base_r;
   assign bus.x_pos       = x_pos_r;
   assign bus.y_pos       = y_pos_r;
   assign bus.tiles_drawn = tiles_drawn_r;

endmodule

// File: tb/tb_tilemap_scanner.sv
// ---------------------------------------------------------------------------
// tb_tilemap_scanner
// Directed bench for tilemap_scanner: map RAM model with one-cycle read
// latency, tile drawer model (active 2 cycles after draw, busy for
// busy_len cycles, optional forced-active override), and a linear sequence
// of directed steps with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_tilemap_scanner;
   import tile_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tilemap_scanner_if bus();

   tilemap_scanner #(.SKIP_ZERO(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Map RAM model: synchronous read, data valid the cycle after map_rd_en.
   logic [IDX_W-1:0] map_mem [0:MAP_COLS*MAP_ROWS-1];
   always @(posedge clk) begin
      if (bus.map_rd_en) bus.map_data <= map_mem[bus.map_addr];
   end

   // Tile drawer model.
   int   dt = 0;
   int   busy_len = 10;
   logic force_active;
   always @(posedge clk or posedge reset) begin
      if (reset)        dt <= 0;
      else if (bus.draw) dt <= 1;
      else if (dt > 0)  dt <= (dt >= 1 + busy_len) ? 0 : dt + 1;
   end
   assign bus.drawer_active = force_active | ((dt >= 2) && (dt < 2 + busy_len));

   // Event monitors.
   int         draw_cnt = 0;
   int         fd_cnt   = 0;
   int         bad_base = 0;
   logic [7:0] last_x   = '0;
   logic [7:0] last_y   = '0;
   always @(posedge clk) begin
      if (bus.draw) begin
         draw_cnt <= draw_cnt + 1;
         last_x   <= bus.x_pos;
         last_y   <= bus.y_pos;
         if (bus.tile_base !== 12'd2880) bad_base <= bad_base + 1;
      end
      if (bus.frame_done) fd_cnt <= fd_cnt + 1;
   end

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Pulse start in the current cycle; afterwards we are in cycle 1.
   task automatic start_frame();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_frame_done(input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         if (bus.frame_done) begin
            at = cyc;
            break;
         end
         step();
      end
   endtask

   task automatic clear_map(input logic [IDX_W-1:0] v);
      for (int i = 0; i < MAP_COLS*MAP_ROWS; i++) map_mem[i] = v;
   endtask

   initial begin
      int at;
      int d0, f0, b0;

      reset        = 1'b1;
      bus.start    = 1'b0;
      force_active = 1'b0;
      busy_len     = 10;
      clear_map('0);

      // ---- reset state ----
      steps(2);
      chk("rst_busy",        32'(bus.busy),        32'd0);
      chk("rst_frame_done",  32'(bus.frame_done),  32'd0);
      chk("rst_draw",        32'(bus.draw),        32'd0);
      chk("rst_map_rd_en",   32'(bus.map_rd_en),   32'd0);
      chk("rst_map_addr",    32'(bus.map_addr),    32'd0);
      chk("rst_tile_base",   32'(bus.tile_base),   32'd0);
      chk("rst_xy",          32'({bus.x_pos, bus.y_pos}), 32'd0);
      chk("rst_tiles_drawn", 32'(bus.tiles_drawn), 32'd0);
      reset = 1'b0;
      steps(2);

      // ---- cell 0 = 5, latency and drawer hand-off ----
      map_mem[0] = 4'd5;
      start_frame();
      chk("t1_rd_en_c1",  32'(bus.map_rd_en), 32'd1);
      chk("t1_addr_c1",   32'(bus.map_addr),  32'd0);
      chk("t1_busy_c1",   32'(bus.busy),      32'd1);
      step();
      chk("t1_nodraw_c2", 32'(bus.draw),      32'd0);
      step();
      chk("t1_draw_c3",   32'(bus.draw),      32'd1);
      chk("t1_base_c3",   32'(bus.tile_base), 32'd960);
      chk("t1_x_c3",      32'(bus.x_pos),     32'd0);
      chk("t1_y_c3",      32'(bus.y_pos),     32'd0);
      at = -1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.map_rd_en) begin
            at = cyc;
            break;
         end
      end
      chk("t1_next_rd_cycle", 32'(at),                32'd17);
      chk("t1_next_addr",     32'(bus.map_addr),      32'd1);
      chk("t1_drawer_idle",   32'(bus.drawer_active), 32'd0);
      wait_frame_done(2000, at);
      chk("t1_done_cycle",    32'(at),                32'd914);
      chk("t1_tiles_drawn",   32'(bus.tiles_drawn),   32'd1);
      chk("t1_busy_in_done",  32'(bus.busy),          32'd0);
      step();
      chk("t1_done_pulse",    32'(bus.frame_done),    32'd0);

      // ---- all-zero map: every cell skipped ----
      clear_map('0);
      d0 = draw_cnt;
      f0 = fd_cnt;
      start_frame();
      wait_frame_done(2000, at);
      chk("t2_done_cycle",  32'(at),              32'd901);
      chk("t2_tiles_drawn", 32'(bus.tiles_drawn), 32'd0);
      step();
      chk("t2_draws",       32'(draw_cnt - d0),   32'd0);
      chk("t2_done_pulses", 32'(fd_cnt - f0),     32'd1);

      // ---- all-15 map, with a stray start mid-frame ----
      clear_map(4'd15);
      d0 = draw_cnt;
      f0 = fd_cnt;
      b0 = bad_base;
      start_frame();
      steps(200);
      chk("t3_busy_mid", 32'(bus.busy), 32'd1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_frame_done(20000, at);
      chk("t3_done_seen",   32'(at >= 0),         32'd1);
      chk("t3_tiles_drawn", 32'(bus.tiles_drawn), 32'd300);
      chk("t3_last_x",      32'(last_x),          32'd152);
      chk("t3_last_y",      32'(last_y),          32'd112);
      chk("t3_tile_base",   32'(bus.tile_base),   32'd2880);
      chk("t3_map_addr",    32'(bus.map_addr),    32'd300);
      steps(5);
      chk("t3_draws",       32'(draw_cnt - d0),   32'd300);
      chk("t3_bad_bases",   32'(bad_base - b0),   32'd0);
      chk("t3_done_pulses", 32'(fd_cnt - f0),     32'd1);
      chk("t3_idle_busy",   32'(bus.busy),        32'd0);

      // ---- drawer busy on entry to MAP_WAIT for 7 cycles ----
      clear_map('0);
      map_mem[0] = 4'd5;
      d0 = draw_cnt;
      start_frame();
      step();                    // cycle 2: MAP_WAIT
      force_active = 1'b1;       // high for cycles 2..8
      chk("t4_nodraw_c2", 32'(bus.draw), 32'd0);
      steps(7);                  // cycle 9
      force_active = 1'b0;
      chk("t4_no_early_draw", 32'(draw_cnt - d0), 32'd0);
      chk("t4_nodraw_c9",     32'(bus.draw),      32'd0);
      step();                    // cycle 10
      chk("t4_draw_c10",      32'(bus.draw),      32'd1);
      chk("t4_base_c10",      32'(bus.tile_base), 32'd960);
      wait_frame_done(2000, at);
      chk("t4_done_seen",     32'(at >= 0),       32'd1);
      step();
      chk("t4_single_draw",   32'(draw_cnt - d0), 32'd1);

      // ---- async reset in WAIT_DONE, then a fresh frame ----
      clear_map('0);
      map_mem[1] = 4'd5;
      start_frame();
      steps(5);                  // cycle 6: ISSUE for cell 1
      chk("t6_draw_c6",   32'(bus.draw),     32'd1);
      chk("t6_x_c6",      32'(bus.x_pos),    32'd8);
      chk("t6_addr_c6",   32'(bus.map_addr), 32'd1);
      steps(4);                  // cycle 10: WAIT_DONE
      chk("t6_pre_tiles", 32'(bus.tiles_drawn),   32'd1);
      chk("t6_pre_busy",  32'(bus.busy),          32'd1);
      chk("t6_pre_active",32'(bus.drawer_active), 32'd1);
      reset = 1'b1;
      #1;
      chk("t6_rst_busy",  32'(bus.busy),        32'd0);
      chk("t6_rst_draw",  32'(bus.draw),        32'd0);
      chk("t6_rst_rd_en", 32'(bus.map_rd_en),   32'd0);
      chk("t6_rst_addr",  32'(bus.map_addr),    32'd0);
      chk("t6_rst_base",  32'(bus.tile_base),   32'd0);
      chk("t6_rst_x",     32'(bus.x_pos),       32'd0);
      chk("t6_rst_tiles", 32'(bus.tiles_drawn), 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("t6_idle_nodraw", 32'(bus.draw), 32'd0);
      start_frame();
      chk("t6_restart_rd",   32'(bus.map_rd_en), 32'd1);
      chk("t6_restart_addr", 32'(bus.map_addr),  32'd0);
      steps(5);
      chk("t6_restart_draw", 32'(bus.draw),      32'd1);
      chk("t6_restart_x",    32'(bus.x_pos),     32'd8);
      wait_frame_done(2000, at);
      chk("t6_done_seen",    32'(at >= 0),       32'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tilemap_scanner.md
Name: tilemap_scanner

Overview:
Upstream sequencer for the tile drawer. On a frame start it walks a 20x15 tile map in row-major order, reading one 4-bit tile index per map cell from a synchronous map RAM. For each cell it computes the tile's pixel-data base address in tile ROM and the cell's screen pixel origin, then issues one draw request to the tile drawer. It waits for that tile to finish before advancing, and pulses frame_done after the last cell.

Parameters:
MAP_COLS, 20, tiles per map row
MAP_ROWS, 15, tile rows per map
TILE_PX, 8, tile edge in pixels (power of two)
TILE_BYTES, 192, ROM bytes per tile (8x8 pixels x 3 bytes RGB)
IDX_W, 4, tile index width
MAP_AW, 9, map RAM address width
ROM_AW, 12, tile ROM address width
SKIP_ZERO, 1, if 1, tile index 0 is empty and is not drawn

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to render a full frame
busy  out  1  high from the cycle after start is accepted until frame_done
frame_done  out  1  one-cycle pulse after the last cell is processed
map_rd_en  out  1  map RAM read strobe
map_addr  out  MAP_AW  map RAM address = row*MAP_COLS+col
map_data  in  IDX_W  tile index, valid the cycle after map_rd_en
draw  out  1  one-cycle draw request to the tile drawer
tile_base  out  ROM_AW  ROM base address of the tile's pixel data
x_pos  out  8  screen x of the tile's top-left pixel
y_pos  out  8  screen y of the tile's top-left pixel
drawer_active  in  1  tile drawer busy flag
tiles_drawn  out  MAP_AW  count of draws issued this frame

Behaviour:
- Reset (async, any state): state=IDLE. All outputs are 0: busy, frame_done, draw, map_rd_en, map_addr, tile_base, x_pos, y_pos and tiles_drawn. Any in-flight tile is abandoned; no further draw is issued.
- States: IDLE, MAP_READ, MAP_WAIT, ISSUE, WAIT_START, WAIT_DONE, ADVANCE, DONE.
- IDLE: when start=1, clear col, row, map_addr and tiles_drawn, set busy=1, and go to MAP_READ. start in any other state is ignored.
- MAP_READ: map_rd_en=1 with the current map_addr, then go to MAP_WAIT.
- MAP_WAIT: register map_data as idx.
  - If SKIP_ZERO and idx==0, go to ADVANCE.
  - Else, if drawer_active==0, go to ISSUE. Otherwise stay in MAP_WAIT, holding idx.
- ISSUE: draw=1 for exactly this cycle. Outputs are driven as follows:
  - tile_base = idx*TILE_BYTES, implemented as (idx<<7)+(idx<<6). This is 12 bits; idx=15 gives 2880.
  - x_pos = col<<3.
  - y_pos = row<<3.
  - tiles_drawn increments.
  - Next state is WAIT_START.
- WAIT_START: stay until drawer_active==1, then go to WAIT_DONE.
- WAIT_DONE: stay until drawer_active==0, then go to ADVANCE.
- tile_base, x_pos and y_pos are held stable from ISSUE until the next ISSUE or reset.
- ADVANCE: map_addr increments by 1 (never computed with a multiplier).
  - If col==MAP_COLS-1: col=0. If row==MAP_ROWS-1, go to DONE; else row+1 and go to MAP_READ.
  - Else: col+1 and go to MAP_READ.
- DONE: frame_done=1 for one cycle, busy=0 in the same cycle, then go to IDLE. A new start is accepted from IDLE on the next cycle.
- Latency: start sampled in cycle 0 leads to map_rd_en in cycle 1, idx latched in cycle 2, and draw in cycle 3 (drawer idle).
- Skipped cell costs 3 cycles (MAP_READ, MAP_WAIT, ADVANCE).
- Last cell (row 14, col 19, map_addr 299): x_pos=152, y_pos=112.
- Width rule: col*8 max 152 and row*8 max 112, both fit in 8 bits.

Decomposition:
- Shared package tile_pkg holds:
  - TILE_PX, TILE_BYTES, MAP_COLS, MAP_ROWS, IDX_W, MAP_AW, ROM_AW;
  - the scanner state enum;
  - screen dimensions 160x120.
- The tile drawer takes its tile and ROM widths from the same package.
- No sub-module is needed; the tile_base shift-add is inline.

Test Plan:
- Map cell 0 = 5, drawer modelled (active 2 cycles after draw, 10 cycles busy) -> draw in cycle 3 with tile_base=960, x_pos=0, y_pos=0. The scanner holds until drawer_active falls, then reads map_addr=1.
- All-zero map, SKIP_ZERO=1 -> no draw pulses, tiles_drawn=0, and frame_done exactly 900 cycles after start (300 cells x 3 cycles) plus the DONE cycle.
- Map all 15 -> 300 draws, tile_base=2880 every time, last draw x_pos=152 and y_pos=112, tiles_drawn=300, then a single frame_done pulse.
- drawer_active held high at entry to MAP_WAIT for 7 cycles -> no draw until it falls; draw then issues exactly once.
- start pulsed again mid-frame -> ignored, frame completes normally.
- Reset asserted in WAIT_DONE -> all outputs 0 immediately (asynchronously); after release, a fresh start restarts from map_addr=0.
